axi_lite_slave_regs: RTL and testbench
======================================

# axi_lite_slave_regs

AXI4-Lite slave (responder) terminating the five channels that the write/read channel masters drive: write address, write data, write response, read address, read data. Holds a bank of NUM_REGS 32-bit registers with byte-strobe writes, independent read and write paths, and SLVERR on out-of-range addresses. Sits at the subordinate end of the AXI4-Lite channel wrapper. Register contents are exported flat for use by downstream logic.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- NUM_REGS, 8, number of 32-bit registers (power of 2, ≥2)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- i_AWADDR  in  ADDR_WIDTH  write byte address
- AWPROT  in  3  accepted, ignored
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- i_WDATA  in  32  write data
- i_WSTRB  in  4  byte strobes, bit n enables WDATA[8n+7:8n]
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- o_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- i_ARADDR  in  ADDR_WIDTH  read byte address
- ARPROT  in  3  accepted, ignored
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- o_RDATA  out  32  read data
- o_RRESP  out  2  read response
- o_REGS  out  32*NUM_REGS  register bank, reg k at [32k+31:32k]

## Operation
- Decode: index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; in range iff addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0.
- Write path: independent one-entry AW buffer (aw_full, address) and W buffer (w_full, data, strobes).
  - AWREADY = !ARESET & !aw_full & !BVALID; WREADY = !ARESET & !w_full & !BVALID.
  - Handshake on VALID & READY at a rising edge; AW and W may arrive in either order or the same cycle.
  - Commit when both are present (buffered, or handshaking this edge): in-range → update enabled bytes only, BRESP=OKAY; out-of-range → no register change, BRESP=SLVERR. On that same edge BVALID←1, both buffers clear.
  - BVALID and o_BRESP hold stable until BREADY; on BVALID&BREADY edge BVALID←0.
  - States: IDLE (neither buffered), HAVE_AW, HAVE_W, RESP (BVALID high). RESP→IDLE on BREADY.
- Read path: ARREADY = !ARESET & !RVALID. On AR handshake edge: RVALID←1, o_RDATA←reg[index], RRESP=OKAY; out of range → o_RDATA=0, RRESP=SLVERR. Held stable until RREADY; RVALID←0 on RVALID&RREADY edge.
- Read and write paths fully independent; a read captured on the same edge as a write commit to the same register returns the pre-write value.
- Reset (async, any time, including mid-transaction): all registers 0, buffers empty, BVALID=0, RVALID=0, o_BRESP=0, o_RRESP=0, o_RDATA=0; all READY outputs 0 while ARESET high. In-flight transactions are dropped, no response issued.

## Timing
- Write latency: BVALID high the cycle after the later of the AW/W handshakes.
- Read latency: RVALID high the cycle after the AR handshake.
- Max throughput: one write per 2 cycles with BREADY held high, one read per 2 cycles with RREADY held high.
- o_REGS reflects a write the cycle after commit (same cycle BVALID rises).
- First READY high: first cycle after ARESET deasserts.

## Test plan
- Reset check: ARESET pulse mid-cycle → all outputs 0 immediately, o_REGS=0; AWREADY/WREADY/ARREADY=1 the cycle after release.
- Full write, AW+W same cycle, addr 0x8, data 0xDEADBEEF, strobe 4'hF → BVALID next cycle, BRESP=00, reg2=0xDEADBEEF; read 0x8 returns it, RRESP=00.
- W two cycles before AW, addr 0x4, data 0x11223344, strobe 4'b0101 over reg1=0xFFFFFFFF → WREADY low after W handshake, reg1=0xFF22FF44, BVALID one cycle after AW.
- Out of range (NUM_REGS=8): write 0x20 → BRESP=10, no register changes; read 0x20 → RDATA=0, RRESP=10.
- Backpressure: BREADY/RREADY held low 5 cycles → BVALID/RVALID, BRESP, RDATA stable, AWREADY/WREADY/ARREADY low throughout; release → accepted, readies return next cycle.
- Reset asserted while BVALID=1 and RVALID=1 → both drop, no response after release, registers 0.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite register bank with byte-strobe writes and SLVERR on out-of-range addresses
module axi_lite_slave_regs #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [ADDR_WIDTH-1:0]    i_AWADDR,
   input  logic [2:0]               AWPROT,
   input  logic                     WVALID,
   output logic                     WREADY,
   input  logic [31:0]              i_WDATA,
   input  logic [3:0]               i_WSTRB,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [1:0]               o_BRESP,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   input  logic [ADDR_WIDTH-1:0]    i_ARADDR,
   input  logic [2:0]               ARPROT,
   output logic                     RVALID,
   input  logic                     RREADY,
   output logic [31:0]              o_RDATA,
   output logic [1:0]               o_RRESP,
   output logic [32*NUM_REGS-1:0]   o_REGS
);
   localparam int IW = $clog2(NUM_REGS);
   typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wstate_e;
   wstate_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
   logic [31:0] w_data_q, wr_data, rdata_q;
   logic [3:0] w_strb_q, wr_strb;
   logic [1:0] bresp_q, rresp_q;
   logic rvalid_q, aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [31:0] regs_q [NUM_REGS];
   logic unused_prot;
   assign unused_prot = ^{AWPROT, ARPROT};
   assign AWREADY = !ARESET && (state_q == IDLE || state_q == HAVE_W);
   assign WREADY  = !ARESET && (state_q == IDLE || state_q == HAVE_AW);
   assign ARREADY = !ARESET && !rvalid_q;
   assign BVALID  = state_q == RESP;
   assign o_BRESP = bresp_q;
   assign RVALID  = rvalid_q;
   assign o_RDATA = rdata_q;
   assign o_RRESP = rresp_q;
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   assign ar_hs   = ARVALID && ARREADY;
   // A channel that handshakes on the commit edge is used directly, not via its buffer
   always_comb begin
      wr_addr = aw_hs ? i_AWADDR : aw_addr_q;
      wr_data = w_hs ? i_WDATA : w_data_q;
      wr_strb = w_hs ? i_WSTRB : w_strb_q;
      wr_idx  = wr_addr[IW+1:2];
      rd_idx  = i_ARADDR[IW+1:2];
      wr_ok   = (wr_addr >> (IW + 2)) == '0;
      rd_ok   = (i_ARADDR >> (IW + 2)) == '0;
      commit  = (aw_hs || state_q == HAVE_AW) && (w_hs || state_q == HAVE_W);
      state_d = state_q;
      if (state_q == RESP) state_d = BREADY ? IDLE : RESP;
      else if (commit) state_d = RESP;
      else if (aw_hs || state_q == HAVE_AW) state_d = HAVE_AW;
      else if (w_hs || state_q == HAVE_W) state_d = HAVE_W;
      else state_d = IDLE;
   end
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (aw_hs) aw_addr_q <= i_AWADDR;
         if (w_hs) begin
            w_data_q <= i_WDATA;
            w_strb_q <= i_WSTRB;
         end
         if (commit) begin
            bresp_q <= wr_ok ? 2'b00 : 2'b10;
            if (wr_ok)
               for (int b = 0; b < 4; b++)
                  if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
         // regs_q here is the pre-write value, so a colliding read sees old data
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? regs_q[rd_idx] : '0;
            rresp_q  <= rd_ok ? 2'b00 : 2'b10;
         end else if (RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
      assign o_REGS[32*k +: 32] = regs_q[k];
   end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed scenario tests for the AXI4-Lite register slave
module tb_axi_lite_slave_regs;
   logic aclk = 1'b0, areset = 1'b1;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
   logic [3:0] wstrb = '0;
   logic [2:0] awprot = '0, arprot = '0;
   logic awready, wready, bvalid, arready, rvalid;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;
   logic [255:0] regs;
   logic [31:0] exp_regs [8];
   logic [255:0] exp_flat;
   logic got_v;
   logic [1:0] got_r;
   logic [31:0] got_d;
   int n_cmp = 0, n_fail = 0;

   axi_lite_slave_regs #(.ADDR_WIDTH(32), .NUM_REGS(8)) dut (
      .ACLK(aclk), .ARESET(areset),
      .AWVALID(awvalid), .AWREADY(awready), .i_AWADDR(awaddr), .AWPROT(awprot),
      .WVALID(wvalid), .WREADY(wready), .i_WDATA(wdata), .i_WSTRB(wstrb),
      .BVALID(bvalid), .BREADY(bready), .o_BRESP(bresp),
      .ARVALID(arvalid), .ARREADY(arready), .i_ARADDR(araddr), .ARPROT(arprot),
      .RVALID(rvalid), .RREADY(rready), .o_RDATA(rdata), .o_RRESP(rresp),
      .o_REGS(regs)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic flatten();
      for (int i = 0; i < 8; i++) exp_flat[32*i +: 32] = exp_regs[i];
   endtask

   // Same-cycle AW+W write; captures the response seen one cycle later, then retires it
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      got_v = bvalid; got_r = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      arvalid = 1'b1; araddr = a;
      tick();
      arvalid = 1'b0;
      got_v = rvalid; got_r = rresp; got_d = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", {awready, wready, arready}); end
      n_cmp++; if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b want 00", {bvalid, rvalid}); end
      n_cmp++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++; $display("FAIL rst_resp: got %h want 0", {bresp, rresp, rdata}); end
      n_cmp++; if (regs !== 256'h0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", regs); end
      areset = 1'b0;
      #1;
      n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL rel_ready: got %b want 111", {awready, wready, arready}); end
      tick();
   endtask

   task automatic test_write_same();
      do_write(32'h8, 32'hDEADBEEF, 4'hF);
      exp_regs[2] = 32'hDEADBEEF; flatten();
      n_cmp++; if (got_v !== 1'b1) begin n_fail++; $display("FAIL ws_bvalid: got %b want 1", got_v); end
      n_cmp++; if (got_r !== 2'b00) begin n_fail++; $display("FAIL ws_bresp: got %b want 00", got_r); end
      n_cmp++; if (regs !== exp_flat) begin n_fail++; $display("FAIL ws_regs: got %h want %h", regs, exp_flat); end
      n_cmp++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL ws_bclr: got %b want 0", bvalid); end
      do_read(32'h8);
      n_cmp++; if ({got_v, got_r, got_d} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin n_fail++; $display("FAIL ws_read: got %b %b %h want 1 00 deadbeef", got_v, got_r, got_d); end
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL ws_rclr: got %b want 0", rvalid); end
   endtask

   task automatic test_w_first();
      do_write(32'h4, 32'hFFFFFFFF, 4'hF);
      wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
      tick();
      wvalid = 1'b0;
      n_cmp++; if ({wready, awready, bvalid} !== 3'b010) begin n_fail++; $display("FAIL wf_buf1: got %b want 010", {wready, awready, bvalid}); end
      tick();
      n_cmp++; if ({wready, awready, bvalid} !== 3'b010) begin n_fail++; $display("FAIL wf_buf2: got %b want 010", {wready, awready, bvalid}); end
      n_cmp++; if (regs[63:32] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wf_early: got %h want ffffffff", regs[63:32]); end
      awvalid = 1'b1; awaddr = 32'h4;
      tick();
      awvalid = 1'b0;
      exp_regs[1] = 32'hFF22FF44; flatten();
      n_cmp++; if ({bvalid, bresp} !== 3'b100) begin n_fail++; $display("FAIL wf_resp: got %b want 100", {bvalid, bresp}); end
      n_cmp++; if (regs !== exp_flat) begin n_fail++; $display("FAIL wf_regs: got %h want %h", regs, exp_flat); end
      bready = 1'b1; tick(); bready = 1'b0;
      n_cmp++; if ({awready, wready, bvalid} !== 3'b110) begin n_fail++; $display("FAIL wf_done: got %b want 110", {awready, wready, bvalid}); end
   endtask

   task automatic test_range();
      do_write(32'h20, 32'h12345678, 4'hF);
      n_cmp++; if ({got_v, got_r} !== 3'b110) begin n_fail++; $display("FAIL or_wresp: got %b %b want 1 10", got_v, got_r); end
      n_cmp++; if (regs !== exp_flat) begin n_fail++; $display("FAIL or_regs: got %h want %h", regs, exp_flat); end
      do_read(32'h20);
      n_cmp++; if ({got_v, got_r, got_d} !== {1'b1, 2'b10, 32'h0}) begin n_fail++; $display("FAIL or_read: got %b %b %h want 1 10 0", got_v, got_r, got_d); end
      do_write(32'h80000008, 32'h12345678, 4'hF);
      n_cmp++; if ({got_r, regs} !== {2'b10, exp_flat}) begin n_fail++; $display("FAIL or_hi: got %b %h want 10 %h", got_r, regs, exp_flat); end
      do_write(32'h1F, 32'hA5A5A5A5, 4'hF);
      exp_regs[7] = 32'hA5A5A5A5; flatten();
      n_cmp++; if ({got_r, regs} !== {2'b00, exp_flat}) begin n_fail++; $display("FAIL or_top: got %b %h want 00 %h", got_r, regs, exp_flat); end
      do_read(32'h1C);
      n_cmp++; if ({got_r, got_d} !== {2'b00, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL or_rtop: got %b %h want 00 a5a5a5a5", got_r, got_d); end
   endtask

   task automatic test_backpressure();
      awvalid = 1'b1; awaddr = 32'h0; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h8;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({bvalid, bresp, rvalid, rresp, rdata} !== {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF}) begin n_fail++; $display("FAIL bp_hold%0d: got %b %b %b %b %h", i, bvalid, bresp, rvalid, rresp, rdata); end
         n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 000", i, {awready, wready, arready}); end
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = 32'hC; wdata = 32'h1; araddr = 32'h0;
         tick();
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
      exp_regs[0] = 32'hCAFEF00D; flatten();
      n_cmp++; if (regs !== exp_flat) begin n_fail++; $display("FAIL bp_regs: got %h want %h", regs, exp_flat); end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      n_cmp++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin n_fail++; $display("FAIL bp_release: got %b want 00111", {bvalid, rvalid, awready, wready, arready}); end
   endtask

   task automatic test_back_to_back();
      awvalid = 1'b1; awaddr = 32'hC; wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'hC; bready = 1'b1; rready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      exp_regs[3] = 32'h55AA55AA; flatten();
      n_cmp++; if ({rvalid, rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bb_oldval: got %b %h want 1 0", rvalid, rdata); end
      n_cmp++; if ({bvalid, regs} !== {1'b1, exp_flat}) begin n_fail++; $display("FAIL bb_commit: got %b %h want 1 %h", bvalid, regs, exp_flat); end
      n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL bb_busy: got %b want 000", {awready, wready, arready}); end
      tick();
      n_cmp++; if ({bvalid, rvalid, awready, arready} !== 4'b0011) begin n_fail++; $display("FAIL bb_free: got %b want 0011", {bvalid, rvalid, awready, arready}); end
      araddr = 32'hC; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_cmp++; if (rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL bb_newval: got %h want 55aa55aa", rdata); end
      tick();
      bready = 1'b0; rready = 1'b0;
   endtask

   task automatic test_reset_mid();
      awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h8;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      n_cmp++; if ({bvalid, rvalid} !== 2'b11) begin n_fail++; $display("FAIL rm_pre: got %b want 11", {bvalid, rvalid}); end
      #2 areset = 1'b1;
      #1;
      n_cmp++; if ({bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready} !== 41'h0) begin n_fail++; $display("FAIL rm_out: got %b %b %b %b %h %b", bvalid, rvalid, bresp, rresp, rdata, {awready, wready, arready}); end
      n_cmp++; if (regs !== 256'h0) begin n_fail++; $display("FAIL rm_regs: got %h want 0", regs); end
      tick();
      areset = 1'b0; bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin n_fail++; $display("FAIL rm_after%0d: got %b want 00111", i, {bvalid, rvalid, awready, wready, arready}); end
      end
      bready = 1'b0; rready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) exp_regs[i] = '0;
      test_reset();
      test_write_same();
      test_w_first();
      test_range();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
